// File: rtl/vga_box_renderer.sv
// Pixel-stage renderer for 640x480 VGA: recovers (x,y) from the registered sync/blank
// stream and draws a white border, a bouncing box and a background, registered to the DAC.
module vga_box_renderer #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter int          BOX_X0    = 100,
  parameter int          BOX_Y0    = 100,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR  = 24'h000040
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic       blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_h_sync_o,
  output logic       vga_v_sync_o,
  output logic       blank_n_o,
  output logic       frame_tick
);

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
  } axis_t;

  localparam logic [10:0] MAX_X   = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] MAX_Y   = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam axis_t       BOX_X_RST = '{pos: 10'(BOX_X0), dir: DIR_INC};
  localparam axis_t       BOX_Y_RST = '{pos: 10'(BOX_Y0), dir: DIR_INC};

  // One axis of motion; 11-bit arithmetic keeps pos+STEP from wrapping near the top.
  function automatic axis_t bounce(input axis_t cur, input logic [10:0] max_pos);
    axis_t       nxt;
    logic [10:0] pos_ext;
    pos_ext = {1'b0, cur.pos};
    nxt     = cur;
    if (cur.dir == DIR_INC) begin
      if (pos_ext + STEP_W >= max_pos) begin
        nxt.pos = max_pos[9:0];
        nxt.dir = DIR_DEC;
      end else begin
        nxt.pos = 10'(pos_ext + STEP_W);
      end
    end else begin
      if (pos_ext <= STEP_W) begin
        nxt.pos = '0;
        nxt.dir = DIR_INC;
      end else begin
        nxt.pos = 10'(pos_ext - STEP_W);
      end
    end
    return nxt;
  endfunction

  logic        bn_q;
  logic        vs_q;
  logic        hs_q;
  logic        tick_q;
  logic [9:0]  x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  axis_t       box_x_q, box_x_d;
  axis_t       box_y_q, box_y_d;
  logic [23:0] rgb_q, rgb_d;
  logic        end_of_line;
  logic        start_of_frame;
  logic        on_border;
  logic        in_box;

  // The edge-detect copies of blank_n/v_sync are exactly the delayed outputs the DAC needs.
  assign end_of_line    = bn_q & ~blank_n;
  assign start_of_frame = vs_q & ~vga_v_sync;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    x_cnt_d = '0;
    y_cnt_d = y_cnt_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;

    if (blank_n) begin
      x_cnt_d = (x_cnt_q == CNT_MAX) ? x_cnt_q : x_cnt_q + 10'd1;
    end

    if (start_of_frame) begin
      y_cnt_d = '0;
    end else if (end_of_line) begin
      y_cnt_d = (y_cnt_q == CNT_MAX) ? y_cnt_q : y_cnt_q + 10'd1;
    end

    // Position only moves at frame start, which falls inside vertical blanking.
    if (start_of_frame) begin
      box_x_d = bounce(box_x_q, MAX_X);
      box_y_d = bounce(box_y_q, MAX_Y);
    end
  end

  always_comb begin
    on_border = (x_cnt_q == '0) || (x_cnt_q == X_LAST) ||
                (y_cnt_q == '0) || (y_cnt_q == Y_LAST);
    in_box    = ({1'b0, x_cnt_q} >= {1'b0, box_x_q.pos}) &&
                ({1'b0, x_cnt_q} <  ({1'b0, box_x_q.pos} + SIZE_W)) &&
                ({1'b0, y_cnt_q} >= {1'b0, box_y_q.pos}) &&
                ({1'b0, y_cnt_q} <  ({1'b0, box_y_q.pos} + SIZE_W));

    rgb_d = '0;
    if (blank_n) begin
      if (on_border) begin
        rgb_d = WHITE;
      end else if (in_box) begin
        rgb_d = BOX_COLOR;
      end else begin
        rgb_d = BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      bn_q    <= 1'b0;
      vs_q    <= 1'b1;
      hs_q    <= 1'b1;
      tick_q  <= 1'b0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      box_x_q <= BOX_X_RST;
      box_y_q <= BOX_Y_RST;
      rgb_q   <= '0;
    end else begin
      bn_q    <= blank_n;
      vs_q    <= vga_v_sync;
      hs_q    <= vga_h_sync;
      tick_q  <= start_of_frame;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_r        = rgb_q[23:16];
  assign vga_g        = rgb_q[15:8];
  assign vga_b        = rgb_q[7:0];
  assign vga_h_sync_o = hs_q;
  assign vga_v_sync_o = vs_q;
  assign blank_n_o    = bn_q;
  assign frame_tick   = tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: drives compressed sync/blank frames, predicts every output
// cycle from pixel coordinates and a bouncing-box model, and pins the model with literals.
module tb_vga_box_renderer;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BOX   = 24'hFF0000;
  localparam logic [23:0] BG    = 24'h000040;
  localparam int          STEP  = 2;
  localparam int          MAX_X = 640 - 32;
  localparam int          MAX_Y = 480 - 32;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        tick;
    logic        chk;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;

  localparam exp_t RESET_EXP = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, bn: 1'b0, tick: 1'b0,
                                 chk: 1'b1, x: 11'd0, y: 11'd0};

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       blank_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_h_sync_o;
  logic       vga_v_sync_o;
  logic       blank_n_o;
  logic       frame_tick;

  vga_box_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .blank_n     (blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_h_sync_o(vga_h_sync_o),
    .vga_v_sync_o(vga_v_sync_o),
    .blank_n_o   (blank_n_o),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ticks_seen = 0;
  int   n_frames = 0;
  exp_t exp_now  = RESET_EXP;
  exp_t exp_pend = RESET_EXP;
  logic exp_valid = 1'b0;
  logic prev_vs = 1'b1;
  logic coords_known = 1'b0;
  int   bx, by, dx, dy;

  int          lit_x[$];
  int          lit_y[$];
  int          lit_hit[$];
  logic [23:0] lit_c[$];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Box as a point reflecting off the walls [0, max].
  function automatic void bounce(input int p, input int d, input int max_pos,
                                 output int p_n, output int d_n);
    p_n = p + d * STEP;
    d_n = d;
    if (p_n >= max_pos) begin
      p_n = max_pos;
      d_n = -1;
    end else if (p_n <= 0) begin
      p_n = 0;
      d_n = 1;
    end
  endfunction

  function automatic logic [23:0] colour(input int x, input int y);
    if (x == 0 || x == 639 || y == 0 || y == 479) return WHITE;
    if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return BOX;
    return BG;
  endfunction

  task automatic model_reset();
    bx = 100;
    by = 100;
    dx = 1;
    dy = 1;
    coords_known = 1'b0;
  endtask

  // One pixel clock: collect what the edge registered, then apply new inputs and predict.
  task automatic step(input logic hs, input logic vs, input logic bn, input int x, input int y);
    logic sof;
    int   p_n, d_n;
    @(posedge clk);
    exp_now   = rst ? RESET_EXP : exp_pend;
    exp_valid = 1'b1;
    prev_vs   = rst ? 1'b1 : vga_v_sync;
    #1;
    vga_h_sync = hs;
    vga_v_sync = vs;
    blank_n    = bn;
    sof = prev_vs & ~vs;
    if (sof) begin
      bounce(bx, dx, MAX_X, p_n, d_n);
      bx = p_n;
      dx = d_n;
      bounce(by, dy, MAX_Y, p_n, d_n);
      by = p_n;
      dy = d_n;
      coords_known = 1'b1;
    end
    exp_pend.hs   = hs;
    exp_pend.vs   = vs;
    exp_pend.bn   = bn;
    exp_pend.tick = sof;
    exp_pend.chk  = !bn || coords_known;
    exp_pend.rgb  = (bn && coords_known) ? colour(x, y) : 24'h0;
    exp_pend.x    = 11'(x);
    exp_pend.y    = 11'(y);
  endtask

  task automatic vsync_pulse();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_frames++;
  endtask

  task automatic line(input int row, input int len);
    for (int i = 0; i < len; i++) step(1, 1, 1, (i > 1023) ? 1023 : i, row);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
  endtask

  // Frame with `rows` visible lines; rows long_a/long_b carry long_len pixels, others one.
  task automatic frame(input int rows, input int long_a, input int long_b, input int long_len);
    vsync_pulse();
    for (int r = 0; r < rows; r++) line(r, (r == long_a || r == long_b) ? long_len : 1);
  endtask

  task automatic lit_add(input int x, input int y, input logic [23:0] c);
    lit_x.push_back(x);
    lit_y.push_back(y);
    lit_c.push_back(c);
    lit_hit.push_back(0);
  endtask

  task automatic lit_close();
    for (int i = 0; i < lit_x.size(); i++) check("literal_pixel_seen", 24'(lit_hit[i] > 0), 24'd1);
    lit_x.delete();
    lit_y.delete();
    lit_c.delete();
    lit_hit.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_valid) begin
      e = rst ? RESET_EXP : exp_now;
      check("h_sync_o", 24'(vga_h_sync_o), 24'(e.hs));
      check("v_sync_o", 24'(vga_v_sync_o), 24'(e.vs));
      check("blank_n_o", 24'(blank_n_o), 24'(e.bn));
      check("frame_tick", 24'(frame_tick), 24'(e.tick));
      if (frame_tick) ticks_seen++;
      if (e.chk) begin
        check("rgb", {vga_r, vga_g, vga_b}, e.rgb);
        if (e.bn) begin
          for (int i = 0; i < lit_x.size(); i++) begin
            if (lit_x[i] == int'(e.x) && lit_y[i] == int'(e.y)) begin
              check("rgb_literal", {vga_r, vga_g, vga_b}, lit_c[i]);
              lit_hit[i]++;
            end
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    blank_n    = 1'b0;
    model_reset();
    repeat (3) step(1, 1, 0, 0, 0);
    #2 rst = 1'b0;
    repeat (2) step(1, 1, 0, 0, 0);

    // Active pixels before any frame start, then an asynchronous reset mid-line.
    repeat (4) step(1, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("reset_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check("reset_h_sync_o", 24'(vga_h_sync_o), 24'd1);
    check("reset_v_sync_o", 24'(vga_v_sync_o), 24'd1);
    check("reset_blank_n_o", 24'(blank_n_o), 24'd0);
    check("reset_frame_tick", 24'(frame_tick), 24'd0);
    model_reset();
    repeat (2) step(1, 1, 0, 0, 0);
    #2 rst = 1'b0;
    repeat (2) step(1, 1, 0, 0, 0);
    check("ticks_after_reset", 24'(ticks_seen), 24'd0);

    // Tick 1: box at (102,102).
    lit_add(0, 0, WHITE);
    lit_add(101, 102, BG);
    lit_add(102, 102, BOX);
    lit_add(133, 133, BOX);
    lit_add(134, 133, BG);
    frame(135, 102, 133, 140);
    lit_close();
    check("ticks_frame1", 24'(ticks_seen), 24'd1);

    // Tick 2: full 480-line frame reaching the bottom-right corner.
    lit_add(639, 479, WHITE);
    lit_add(639, 1, WHITE);
    lit_add(320, 1, BG);
    frame(480, 1, 479, 640);
    lit_close();
    check("ticks_frame2", 24'(ticks_seen), 24'd2);

    while (n_frames < 253) vsync_pulse();
    check("ticks_253", 24'(ticks_seen), 24'd253);

    // Tick 254: right wall reached, box at (608,288).
    lit_add(607, 288, BG);
    lit_add(608, 288, BOX);
    lit_add(639, 288, WHITE);
    frame(289, 288, -1, 640);
    lit_close();

    // Tick 255: moving left, box at (606,286).
    lit_add(605, 286, BG);
    lit_add(606, 286, BOX);
    lit_add(637, 286, BOX);
    lit_add(638, 286, BG);
    frame(287, 286, -1, 640);
    lit_close();

    while (n_frames < 557) vsync_pulse();

    // Tick 558: left wall reached, box at (0,320); border still wins at x=0.
    lit_add(0, 320, WHITE);
    lit_add(1, 320, BOX);
    lit_add(31, 320, BOX);
    lit_add(32, 320, BG);
    frame(321, 320, -1, 40);
    lit_close();

    // Tick 559: moving right again, box at (2,322).
    lit_add(1, 322, BG);
    lit_add(2, 322, BOX);
    lit_add(33, 322, BOX);
    lit_add(34, 322, BG);
    frame(323, 322, -1, 40);
    lit_close();

    // Tick 560: 1100-pixel line, x must saturate at 1023 without wrapping.
    lit_add(700, 1, BG);
    lit_add(1023, 1, BG);
    frame(2, 1, -1, 1100);
    lit_close();
    repeat (3) step(1, 1, 0, 0, 0);
    check("ticks_final", 24'(ticks_seen), 24'd560);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
